norm_rr_scheduler: RTL



---
 rtl/norm_sched_pkg.sv | 20 ++
 rtl/lzc.sv | 40 ++++
 rtl/rr_arb.sv | 56 +++++
 rtl/norm_rr_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/norm_sched_pkg.sv
// Shared defaults and result types for the normalising round-robin scheduler.
package norm_sched_pkg;

   localparam int unsigned DEFAULT_NUM_REQ   = 4;
   localparam int unsigned DEFAULT_WIDTH     = 32;
   localparam int unsigned DEFAULT_CNT_WIDTH = $clog2(DEFAULT_WIDTH);
   localparam int unsigned DEFAULT_ID_WIDTH  = $clog2(DEFAULT_NUM_REQ);

   typedef logic [DEFAULT_ID_WIDTH-1:0]  id_t;
   typedef logic [DEFAULT_CNT_WIDTH-1:0] cnt_t;

   // One normalised result as presented on the output port group.
   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] data;
      cnt_t                     cnt;
      logic                     empty;
      id_t                      id;
   } result_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=1 counts leading zeros, MODE=0 trailing.
// An all-zero input reports empty_o=1 with cnt_o=WIDTH-1.
module lzc #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MODE      = 1'b0,
   parameter int unsigned CNT_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   logic [WIDTH-1:0] in_ord;

   // Bit-reverse for leading-zero mode so the scan always starts at index 0.
   always_comb begin
      in_ord = in_i;
      if (MODE) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            in_ord[i] = in_i[WIDTH-1-i];
         end
      end
   end

   // First-one scan; the first set bit found wins.
   always_comb begin
      logic found;
      found   = 1'b0;
      cnt_o   = CNT_WIDTH'(WIDTH-1);
      empty_o = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!found && in_ord[i]) begin
            found   = 1'b1;
            cnt_o   = CNT_WIDTH'(i);
            empty_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting from ptr, pointer
// advances past the winner only when the grant is taken (en_i).
module rr_arb #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_REQ-1:0]  valid_i,
   input  logic                en_i,
   output logic [NUM_REQ-1:0]  grant_o,
   output logic [ID_WIDTH-1:0] grant_id_o
);

   logic [ID_WIDTH-1:0] ptr_q;
   logic [ID_WIDTH-1:0] ptr_d;
   logic                any_grant;

   // Priority scan ptr, ptr+1, ..., wrapping back to ptr-1.
   always_comb begin
      int unsigned idx;
      grant_o    = '0;
      grant_id_o = '0;
      any_grant  = 1'b0;
      idx        = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!any_grant && valid_i[idx]) begin
            any_grant    = 1'b1;
            grant_o[idx] = 1'b1;
            grant_id_o   = ID_WIDTH'(idx);
         end
      end
   end

   // Next pointer is one past the winner, modulo NUM_REQ.
   always_comb begin
      ptr_d = grant_id_o + ID_WIDTH'(1);
      if (grant_id_o == ID_WIDTH'(NUM_REQ-1)) begin
         ptr_d = '0;
      end
   end

   // Pointer register; holds when nothing is accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (en_i && any_grant) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/norm_rr_scheduler.sv
// Shares one leading-zero counter and normalising shifter among NUM_REQ
// requesters. Round-robin select, two registered stages, valid/ready flow.
module norm_rr_scheduler
   import norm_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ   = DEFAULT_NUM_REQ,
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned CNT_WIDTH = $clog2(WIDTH),
   parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [WIDTH-1:0]         out_data_o,
   output logic [CNT_WIDTH-1:0]     out_cnt_o,
   output logic                     out_empty_o,
   output logic [ID_WIDTH-1:0]      out_id_o,
   output logic                     busy_o
);

   logic [NUM_REQ-1:0]   grant;
   logic [ID_WIDTH-1:0]  grant_id;
   logic [WIDTH-1:0]     sel_data;

   logic                 s1_valid_q;
   logic [WIDTH-1:0]     s1_data_q;
   logic [ID_WIDTH-1:0]  s1_id_q;

   logic                 out_valid_q;
   logic [WIDTH-1:0]     out_data_q;
   logic [CNT_WIDTH-1:0] out_cnt_q;
   logic                 out_empty_q;
   logic [ID_WIDTH-1:0]  out_id_q;
   logic                 busy_q;

   logic                 s2_ready;
   logic                 s1_ready;
   logic                 accept;
   logic                 s1_valid_d;
   logic                 out_valid_d;

   logic [CNT_WIDTH-1:0] lz_cnt;
   logic                 lz_empty;
   logic [WIDTH-1:0]     shifted;

   rr_arb #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (req_valid_i),
      .en_i       (s1_ready),
      .grant_o    (grant),
      .grant_id_o (grant_id)
   );

   // Pipeline flow control and next valid bits.
   always_comb begin
      s2_ready    = !out_valid_q || out_ready_i;
      s1_ready    = !s1_valid_q || s2_ready;
      accept      = s1_ready && (|grant);
      s1_valid_d  = s1_ready ? accept : s1_valid_q;
      out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
   end

   assign req_ready_o = grant & {NUM_REQ{s1_ready}};

   // AND-OR mux of the granted requester's mantissa.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_data = sel_data | req_data_i[i*WIDTH +: WIDTH];
         end
      end
   end

   // Stage 1 register: captured operand and its requester ID.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_id_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (accept) begin
            s1_data_q <= sel_data;
            s1_id_q   <= grant_id;
         end
      end
   end

   lzc #(
      .WIDTH     (WIDTH),
      .MODE      (1'b1),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_lzc (
      .in_i    (s1_data_q),
      .cnt_o   (lz_cnt),
      .empty_o (lz_empty)
   );

   // Normalising shift; an all-zero operand yields zero regardless of count.
   always_comb begin
      shifted = s1_data_q << lz_cnt;
      if (lz_empty) begin
         shifted = '0;
      end
   end

   // Output register: loads when stage 1 holds data and the consumer side can move.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_empty_q <= 1'b0;
         out_id_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (s2_ready && s1_valid_q) begin
            out_data_q  <= shifted;
            out_cnt_q   <= lz_cnt;
            out_empty_q <= lz_empty;
            out_id_q    <= s1_id_q;
         end
      end
   end

   // Busy flag registered from the next-state valids of both stages.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= s1_valid_d || out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_cnt_o   = out_cnt_q;
   assign out_empty_o = out_empty_q;
   assign out_id_o    = out_id_q;
   assign busy_o      = busy_q;

endmodule
